// File: rtl/audio_pkg.sv
// Shared definitions for the audio mixer slice: widths, default channel
// count and the mixer FSM state encoding.
package audio_pkg;

    localparam int unsigned NUM_CH_DEFAULT = 4;
    localparam int unsigned SAMPLE_W       = 8;
    localparam int unsigned SUM_W          = 10;
    localparam int unsigned VOL_W          = 4;
    // sum * (vol + 1) needs SUM_W + VOL_W + 1 bits at full range
    localparam int unsigned PROD_W         = 15;
    localparam int unsigned SCALED_W       = PROD_W - 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } mix_state_e;

endpackage : audio_pkg

// File: rtl/audio_mixer_if.sv
// Mixer control/data bundle.
//   master: drives channel samples, enables, master volume, tick, clear_flags
//   slave : the mixer; returns busy, mix_sample, mix_valid, clip, overrun
interface audio_mixer_if
    import audio_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEFAULT
) ();

    logic [NUM_CH*SAMPLE_W-1:0] ch_sample;
    logic [NUM_CH-1:0]          ch_enable;
    logic [VOL_W-1:0]           master_vol;
    logic                       sample_tick;
    logic                       clear_flags;
    logic                       busy;
    logic [SAMPLE_W-1:0]        mix_sample;
    logic                       mix_valid;
    logic                       clip;
    logic                       overrun;

    modport master (
        output ch_sample, ch_enable, master_vol, sample_tick, clear_flags,
        input  busy, mix_sample, mix_valid, clip, overrun
    );

    modport slave (
        input  ch_sample, ch_enable, master_vol, sample_tick, clear_flags,
        output busy, mix_sample, mix_valid, clip, overrun
    );

endinterface : audio_mixer_if

// File: rtl/audio_sdm.sv
// First-order sigma-delta modulator: the carry out of an 8-bit phase
// accumulator, registered once more, forms the 1-bit output stream.
//   clk_1mhz : clock
//   rst      : synchronous active-high reset
//   sample   : value to modulate
//   bit_out  : density-modulated bitstream (sample/256 ones density)
module audio_sdm
    import audio_pkg::*;
(
    input  logic                clk_1mhz,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                bit_out
);

    logic [SAMPLE_W-1:0] acc_q, acc_d;
    logic                carry_q, carry_d;
    logic                bit_q, bit_d;

    // Accumulate and take the carry; output lags the carry by one cycle
    always_comb begin
        {carry_d, acc_d} = (SAMPLE_W + 1)'(acc_q) + (SAMPLE_W + 1)'(sample);
        bit_d            = carry_q;
    end

    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            bit_q   <= bit_d;
        end
    end

    assign bit_out = bit_q;

endmodule : audio_sdm

// File: rtl/audio_mixer.sv
// Multi-channel sample mixer: on a tick, latches the enabled channel
// samples, sums them one per cycle, scales by (master_vol + 1) / 16 with
// saturation, and feeds the result to a sigma-delta bitstream output.
//   clk_1mhz  : clock
//   rst       : synchronous active-high reset
//   bus       : audio_mixer_if slave (samples, mask, volume, tick, flags)
//   audio_out : sigma-delta bitstream of mix_sample
module audio_mixer
    import audio_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEFAULT
) (
    input  logic          clk_1mhz,
    input  logic          rst,
    audio_mixer_if.slave  bus,
    output logic          audio_out
);

    localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LAT_W   = NUM_CH * SAMPLE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    mix_state_e           state_q, state_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PROD_W-1:0]    product_q, product_d;
    logic [SAMPLE_W-1:0]  mix_sample_q, mix_sample_d;
    logic                 mix_valid_q, mix_valid_d;
    logic                 busy_q, busy_d;
    logic                 clip_q, clip_d;
    logic                 overrun_q, overrun_d;

    logic [LAT_W-1:0]     masked;
    logic [SAMPLE_W-1:0]  chan;
    logic [SCALED_W-1:0]  scaled;
    logic                 clip_set;
    logic                 overrun_set;

    // Zero disabled channels before latching
    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            masked[i*SAMPLE_W +: SAMPLE_W] =
                bus.ch_sample[i*SAMPLE_W +: SAMPLE_W] & {SAMPLE_W{bus.ch_enable[i]}};
        end
    end

    assign chan   = lat_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W];
    assign scaled = product_q[PROD_W-1:4];

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        sum_d        = sum_q;
        idx_d        = idx_q;
        product_d    = product_q;
        mix_sample_d = mix_sample_q;
        mix_valid_d  = 1'b0;
        busy_d       = busy_q;
        clip_set     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.sample_tick) begin
                    lat_d   = masked;
                    sum_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                sum_d = sum_q + SUM_W'(chan);
                if (idx_q == LAST_IDX) begin
                    state_d = SCALE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            SCALE: begin
                // sum * (vol + 1) as sum * vol + sum keeps the multiplier 4x10
                product_d = PROD_W'(sum_q) * PROD_W'(bus.master_vol) + PROD_W'(sum_q);
                state_d   = OUT;
            end
            OUT: begin
                if (scaled > SCALED_W'(255)) begin
                    mix_sample_d = '1;
                    clip_set     = 1'b1;
                end else begin
                    mix_sample_d = scaled[SAMPLE_W-1:0];
                end
                mix_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Any tick outside IDLE is dropped and flagged
        overrun_set = bus.sample_tick && busy_q;

        // Sticky flags: a set on the same edge as a clear wins
        clip_d    = clip_set    ? 1'b1 : (bus.clear_flags ? 1'b0 : clip_q);
        overrun_d = overrun_set ? 1'b1 : (bus.clear_flags ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            sum_q        <= '0;
            idx_q        <= '0;
            product_q    <= '0;
            mix_sample_q <= '0;
            mix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            clip_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            sum_q        <= sum_d;
            idx_q        <= idx_d;
            product_q    <= product_d;
            mix_sample_q <= mix_sample_d;
            mix_valid_q  <= mix_valid_d;
            busy_q       <= busy_d;
            clip_q       <= clip_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.mix_sample = mix_sample_q;
    assign bus.mix_valid  = mix_valid_q;
    assign bus.clip       = clip_q;
    assign bus.overrun    = overrun_q;

    audio_sdm u_sdm (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .sample   (mix_sample_q),
        .bit_out  (audio_out)
    );

endmodule : audio_mixer
